fetch_unit: RTL and testbench

Instruction fetch stage of the RV32 pipeline. It owns the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction into the IF/ID register. It hands that register to decode over a valid/ready handshake and accepts PC redirects from execute. An optional static JAL predictor is available.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_jal_pred.sv | 23 ++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
//==============================================================================
// Package : fetch_pkg
// Shared constants, FSM state type and J-immediate decode for fetch_unit.
// Rev     : 1.0
//==============================================================================
package fetch_pkg;

    localparam logic [6:0]  OPC_JAL   = 7'b1101111;
    localparam logic [31:0] INST_HALT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Takes only inst[31:12]; the low bits play no part in the J-immediate.
    function automatic logic [31:0] jimm(input logic [31:12] inst_hi);
        return {{12{inst_hi[31]}}, inst_hi[19:12], inst_hi[20], inst_hi[30:21], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_jal_pred.sv
`default_nettype none
//==============================================================================
// Module : fetch_jal_pred
// Combinational static JAL predictor: steers next PC to the JAL target.
// Rev    : 1.0
//==============================================================================
module fetch_jal_pred
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    output logic [31:0] next_pc_o,
    output logic        pred_taken_o
);

    logic unused_inst_bits;

    assign pred_taken_o     = (inst_i[6:0] == OPC_JAL);
    assign next_pc_o        = pc_i + (pred_taken_o ? jimm(inst_i[31:12]) : 32'd4);
    assign unused_inst_bits = ^inst_i[11:7];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
//==============================================================================
// Module : fetch_unit
// RV32 fetch stage: PC, IF/ID register, redirect and halt handling.
// Optional static JAL prediction enabled by defining FETCH_JAL_PREDICT_EN.
// Rev    : 1.0
//==============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_pred_taken,
    output logic        halted,
    output logic [31:0] fetch_count
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic         id_valid_q;
    logic [31:0]  id_pc_q;
    logic [31:0]  id_inst_q;
    logic         id_pred_q;
    logic         halted_q;
    logic [31:0]  fetch_count_q;

    logic [31:0]  next_pc_d;
    logic         pred_d;
    logic         load;
    logic         halt_word;
    logic [31:0]  redirect_tgt;
    logic         unused_redirect_bits;

`ifdef FETCH_JAL_PREDICT_EN
    fetch_jal_pred u_jal_pred (
        .pc_i         (pc_q),
        .inst_i       (imem_data),
        .next_pc_o    (next_pc_d),
        .pred_taken_o (pred_d)
    );
`else
    assign next_pc_d = pc_q + 32'd4;
    assign pred_d    = 1'b0;
`endif

    // Redirect suppresses the load so the same-cycle imem_data is discarded.
    assign load                 = (state_q == RUN) && !redirect_valid && (!id_valid_q || id_ready);
    assign halt_word            = (imem_data == INST_HALT);
    assign redirect_tgt         = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_pc_q       <= 32'd0;
            id_inst_q     <= 32'd0;
            id_pred_q     <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            if (id_valid_q && id_ready && !redirect_valid) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end

            case (state_q)
                BOOT: begin
                    state_q <= RUN;
                end
                default: begin
                    if (redirect_valid) begin
                        pc_q       <= redirect_tgt;
                        id_valid_q <= 1'b0;
                        id_pred_q  <= 1'b0;
                        state_q    <= RUN;
                        halted_q   <= 1'b0;
                    end else if (load) begin
                        if (halt_word) begin
                            state_q    <= HALT;
                            halted_q   <= 1'b1;
                            id_valid_q <= 1'b0;
                        end else begin
                            id_inst_q  <= imem_data;
                            id_pc_q    <= pc_q;
                            id_pred_q  <= pred_d;
                            id_valid_q <= 1'b1;
                            pc_q       <= next_pc_d;
                        end
                    end else if (id_valid_q && id_ready) begin
                        id_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign imem_addr     = pc_q;
    assign id_valid      = id_valid_q;
    assign id_pc         = id_pc_q;
    assign id_inst       = id_inst_q;
    assign id_pred_taken = id_pred_q;
    assign halted        = halted_q;
    assign fetch_count   = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
//==============================================================================
// Module : tb_fetch_unit
// Directed self-checking bench for fetch_unit with a combinational memory.
// Rev    : 1.0
//==============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_pred_taken;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:63];
    int total = 0;
    int bad   = 0;

`ifdef FETCH_JAL_PREDICT_EN
    localparam logic [31:0] c_jal_next = 32'h0000_0034;
    localparam logic [31:0] c_jal_pred = 32'd1;
`else
    localparam logic [31:0] c_jal_next = 32'h0000_005C;
    localparam logic [31:0] c_jal_pred = 32'd0;
`endif

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_pred_taken  (id_pred_taken),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 32'h100) ? mem[imem_addr[7:2]] : 32'h0000_0013;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // LUI rd=i at word i; JAL at 0x58; halt word at 0x70.
        for (int i = 0; i < 64; i++) mem[i] = (32'(i) << 7) | 32'h37;
        mem[22] = 32'hFDDF_F46F;
        mem[28] = 32'h0000_0000;

        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        rstn           = 1'b1;
        #1 rstn = 1'b0;
        #2;
        check_val("rst_addr",  imem_addr,     32'h0);
        check_val("rst_valid", id_valid,      32'd0);
        check_val("rst_halt",  halted,        32'd0);
        check_val("rst_cnt",   fetch_count,   32'd0);
        check_val("rst_idpc",  id_pc,         32'd0);
        check_val("rst_inst",  id_inst,       32'd0);
        check_val("rst_pred",  id_pred_taken, 32'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        tick();
        check_val("boot_valid", id_valid,  32'd0);
        check_val("boot_addr",  imem_addr, 32'h0);
        tick();
        check_val("f0_valid", id_valid,    32'd1);
        check_val("f0_pc",    id_pc,       32'h0);
        check_val("f0_inst",  id_inst,     32'h37);
        check_val("f0_addr",  imem_addr,   32'h4);
        check_val("f0_cnt",   fetch_count, 32'd0);
        tick();
        check_val("f1_pc",  id_pc,       32'h4);
        check_val("f1_cnt", fetch_count, 32'd1);
        tick();
        check_val("f2_pc",  id_pc,       32'h8);
        check_val("f2_cnt", fetch_count, 32'd2);

        id_ready = 1'b0;
        repeat (3) tick();
        check_val("stall_pc",    id_pc,       32'h8);
        check_val("stall_inst",  id_inst,     32'h137);
        check_val("stall_addr",  imem_addr,   32'hC);
        check_val("stall_valid", id_valid,    32'd1);
        check_val("stall_cnt",   fetch_count, 32'd2);
        id_ready = 1'b1;
        tick();
        check_val("rel_pc",   id_pc,       32'hC);
        check_val("rel_inst", id_inst,     32'h1B7);
        check_val("rel_cnt",  fetch_count, 32'd3);
        check_val("rel_addr", imem_addr,   32'h10);

        id_ready = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        tick();
        check_val("rd_addr",  imem_addr,   32'h40);
        check_val("rd_valid", id_valid,    32'd0);
        check_val("rd_cnt",   fetch_count, 32'd3);
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        tick();
        check_val("rd_pc",    id_pc,    32'h40);
        check_val("rd_inst",  id_inst,  32'h837);
        check_val("rd_valid2", id_valid, 32'd1);
        tick();
        check_val("rd_pc2",  id_pc,       32'h44);
        check_val("rd_cnt2", fetch_count, 32'd4);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h58;
        tick();
        check_val("jr_cnt",  fetch_count, 32'd4);
        check_val("jr_addr", imem_addr,   32'h58);
        redirect_valid = 1'b0;
        tick();
        check_val("jal_pc",   id_pc,         32'h58);
        check_val("jal_inst", id_inst,       32'hFDDF_F46F);
        check_val("jal_addr", imem_addr,     c_jal_next);
        check_val("jal_pred", id_pred_taken, c_jal_pred);
        tick();
        check_val("jal_tgt_pc",   id_pc,         c_jal_next);
        check_val("jal_tgt_pred", id_pred_taken, 32'd0);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h68;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        check_val("pre_halt_pc",   id_pc,     32'h6C);
        check_val("pre_halt_addr", imem_addr, 32'h70);
        tick();
        check_val("halt_flag",  halted,    32'd1);
        check_val("halt_valid", id_valid,  32'd0);
        check_val("halt_addr",  imem_addr, 32'h70);
        tick();
        check_val("halt_flag2", halted,      32'd1);
        check_val("halt_addr2", imem_addr,   32'h70);
        check_val("halt_valid2", id_valid,   32'd0);
        check_val("halt_cnt",   fetch_count, 32'd7);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        check_val("unhalt_flag",  halted,    32'd0);
        check_val("unhalt_addr",  imem_addr, 32'h0);
        check_val("unhalt_valid", id_valid,  32'd0);
        redirect_valid = 1'b0;
        tick();
        check_val("resume_valid", id_valid,  32'd1);
        check_val("resume_pc",    id_pc,     32'h0);
        check_val("resume_inst",  id_inst,   32'h37);
        check_val("resume_addr",  imem_addr, 32'h4);

        #3 rstn = 1'b0;
        #1;
        check_val("arst_addr",  imem_addr,   32'h0);
        check_val("arst_valid", id_valid,    32'd0);
        check_val("arst_pc",    id_pc,       32'h0);
        check_val("arst_inst",  id_inst,     32'h0);
        check_val("arst_cnt",   fetch_count, 32'd0);
        check_val("arst_halt",  halted,      32'd0);
        tick();
        @(negedge clk);
        rstn           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        check_val("rboot_addr",  imem_addr, 32'h0);
        check_val("rboot_valid", id_valid,  32'd0);
        redirect_valid = 1'b0;
        tick();
        check_val("rf0_valid", id_valid,  32'd1);
        check_val("rf0_pc",    id_pc,     32'h0);
        check_val("rf0_addr",  imem_addr, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
